fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the instruction-memory address.
- Buffers fetched instructions, each with its PC+1, in a small circular prefetch queue, so fetch keeps running while ID stalls.
- Presents the queue head to IF/ID. On a redirect (jump, branch mispredict, return), it flushes the queue and restarts fetch at the redirect target.

Parameters:
- ADDRESS_LEN, 12, width of PC and instruction-memory address
- INSTRUCTION_LEN, 19, instruction width
- DEPTH, 4, queue entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDRESS_LEN  equals fetch_pc; instruction memory reads combinationally in the same cycle
- imem_rdata  in  INSTRUCTION_LEN  instruction at imem_addr
- redirect_valid  in  1  PC redirect request from ID/EX control
- redirect_pc  in  ADDRESS_LEN  redirect target
- deq_en  in  1  IF/ID write enable; consumes the head entry when out_valid=1
- out_valid  out  1  head entry present
- out_instruction  out  INSTRUCTION_LEN  head instruction; NOP (all zeros) when out_valid=0
- out_pc_plus1  out  ADDRESS_LEN  PC+1 of the head instruction; 0 when out_valid=0
- count  out  $clog2(DEPTH)+1  current occupancy
- fetch_pc  out  ADDRESS_LEN  current fetch PC

Behaviour:
- Reset:
  - fetch_pc=0, read/write pointers=0, count=0.
  - out_valid=0, out_instruction=0, out_pc_plus1=0.
  - Reset wins over every other input in that cycle.
- Outputs: out_* are driven combinationally from the head entry, so an entry is visible one cycle after it is enqueued. Fetch-to-IF/ID latency is 1 cycle.
- Enqueue condition: enq = ~redirect_valid & (count<DEPTH | deq).
- Dequeue condition: deq = deq_en & out_valid & ~redirect_valid.
- On enq:
  - Entry {imem_rdata, fetch_pc+1} is written at the write pointer.
  - Write pointer increments mod DEPTH.
  - fetch_pc <= fetch_pc+1, wrapping 0xFFF->0x000 (ADDRESS_LEN-bit modular add).
- On deq: read pointer increments mod DEPTH.
- count update:
  - count+1 on enq only.
  - count-1 on deq only.
  - Unchanged when both occur, or neither.
- Full (count=DEPTH):
  - Without deq: no enqueue, fetch_pc holds, imem_addr holds.
  - With deq: simultaneous enqueue and dequeue; count stays DEPTH.
- Empty (count=0):
  - out_valid=0; IF/ID receives the NOP bubble; deq_en is ignored.
  - The entry fetched this cycle becomes visible next cycle; there is no same-cycle bypass.
- Redirect (highest priority after rst):
  - Pointers and count clear to 0; fetch_pc <= redirect_pc.
  - No enqueue and no dequeue that cycle.
  - Next cycle: out_valid=0 and imem_addr=redirect_pc.
  - A redirect asserted on consecutive cycles takes the last target.
- Pointers are $clog2(DEPTH) bits with natural wrap. count distinguishes full from empty.
- No illegal states. imem_rdata is never stored while redirect_valid=1.
- Single clock domain; no combinational path from deq_en to imem_addr.

Decomposition:
- Shared package cpu_pkg:
  - ADDRESS_LEN=12, INSTRUCTION_LEN=19, WORD_LEN=8.
  - NOP_INSTRUCTION = 19'b0.
  - typedef fetch_entry_t = struct {instruction, pc_plus1}.
- Sub-module fetch_fifo_mem:
  - DEPTH x fetch_entry_t register array with one write port and one asynchronous read port.
  - Holds the pointers and count, with a flush input.
- fetch_queue holds the fetch-PC register, the enq/deq/redirect control, and the output NOP muxing.

Test Plan:
- Reset, then idle with deq_en=0 and imem_rdata=addr-derived pattern:
  - imem_addr sequence 0,1,2,3, then holds at 4.
  - count=4; out_instruction=mem[0]; out_pc_plus1=1.
- Full queue, deq_en=1 continuous:
  - One instruction per cycle out, in order mem[0],mem[1],...
  - count stays 4; fetch_pc advances by 1 each cycle.
- count=3, head pc_plus1=6, redirect_valid=1 with redirect_pc=0x120, deq_en=1:
  - Next cycle out_valid=0, count=0, out_instruction=0, imem_addr=0x120.
  - The cycle after, out_pc_plus1=0x121.
- redirect_pc=0xFFE, deq_en=1 continuous:
  - imem_addr 0xFFE,0xFFF,0x000,0x001.
  - Entry pc_plus1 values 0xFFF,0x000,0x001.
- Empty queue with deq_en=1 in the cycle immediately after a redirect:
  - No underflow; count goes to 1 (enqueue only).
  - Read pointer unchanged; out_valid=1 next cycle.
- rst asserted mid-stream with count=2 and redirect_valid=1 in the same cycle:
  - Next cycle fetch_pc=0 (not redirect_pc), count=0, out_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the fetch queue entry record.
package cpu_pkg;
  localparam int ADDRESS_LEN     = 12;
  localparam int INSTRUCTION_LEN = 19;
  localparam int WORD_LEN        = 8;

  localparam logic [INSTRUCTION_LEN-1:0] NOP_INSTRUCTION = '0;

  // One prefetched instruction together with the PC that follows it.
  typedef struct packed {
    logic [INSTRUCTION_LEN-1:0] instruction;
    logic [ADDRESS_LEN-1:0]     pc_plus1;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction memory, redirect, and IF/ID head port.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  import cpu_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDRESS_LEN-1:0]     imem_addr;
  logic [INSTRUCTION_LEN-1:0] imem_rdata;
  logic                       redirect_valid;
  logic [ADDRESS_LEN-1:0]     redirect_pc;
  logic                       deq_en;
  logic                       out_valid;
  logic [INSTRUCTION_LEN-1:0] out_instruction;
  logic [ADDRESS_LEN-1:0]     out_pc_plus1;
  logic [CW-1:0]              count;
  logic [ADDRESS_LEN-1:0]     fetch_pc;

  // master is the fetch queue itself; slave is memory plus downstream control.
  modport master (
    output imem_addr, out_valid, out_instruction, out_pc_plus1, count, fetch_pc,
    input  imem_rdata, redirect_valid, redirect_pc, deq_en
  );
  modport slave (
    input  imem_addr, out_valid, out_instruction, out_pc_plus1, count, fetch_pc,
    output imem_rdata, redirect_valid, redirect_pc, deq_en
  );
endinterface

// File: rtl/fetch_fifo_mem.sv
// Circular entry store for the fetch queue: one write port, one async read
// port, pointers and occupancy, with a flush that empties it in one cycle.
module fetch_fifo_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  fetch_entry_t              wr_data,
  input  logic                      rd_en,
  output fetch_entry_t              rd_data,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Entry storage; callers never write during flush, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; count tells full apart from empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, prefetches into a small
// queue so fetch keeps running while ID stalls, and flushes on redirect.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  fetch_queue_if.master     bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDRESS_LEN-1:0] fetch_pc;
  logic [CW-1:0]          count;
  logic                   out_valid;
  logic                   enq;
  logic                   deq;
  fetch_entry_t           wr_entry;
  fetch_entry_t           head;

  assign out_valid = (count != '0);
  // Redirect kills both sides of the queue for the cycle; a full queue can
  // still accept when the head leaves in the same cycle.
  assign deq = bus.deq_en & out_valid & ~bus.redirect_valid;
  assign enq = ~bus.redirect_valid & ((count < CW'(DEPTH)) | deq);

  assign wr_entry.instruction = bus.imem_rdata;
  assign wr_entry.pc_plus1    = fetch_pc + 1'b1;

  fetch_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.redirect_valid),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count)
  );

  // Fetch PC: reset to 0, jump on redirect, advance whenever an entry is taken.
  always_ff @(posedge clk) begin
    if (rst)                     fetch_pc <= '0;
    else if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
    else if (enq)                fetch_pc <= fetch_pc + 1'b1;
  end

  // Head presentation; an empty queue hands IF/ID a NOP bubble.
  always_comb begin
    bus.out_instruction = NOP_INSTRUCTION;
    bus.out_pc_plus1    = '0;
    if (out_valid) begin
      bus.out_instruction = head.instruction;
      bus.out_pc_plus1    = head.pc_plus1;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.count     = count;
  assign bus.fetch_pc  = fetch_pc;
  assign bus.imem_addr = fetch_pc;
endmodule
